// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_engine_pkg
//   Shared definitions for the block-copy engine: default memory geometry
//   and the FSM state encoding used by the engine and anything that needs
//   to decode its state.
package mem_copy_engine_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Copies len words from srcAddr to dstAddr in a single-port data memory,
//   one READ cycle and one WRITE cycle per word, ascending order, while
//   accumulating a modulo-2^DATA_W sum of the words moved.
//
// Ports
//   clk      in   single clock, rising-edge state updates
//   rst_n    in   asynchronous active-low reset
//   start    in   copy request, only looked at in IDLE
//   srcAddr  in   first source word address
//   dstAddr  in   first destination word address
//   len      in   number of words (0 allowed)
//   busy     out  high from the cycle after an accepted start through DONE
//   done     out  one-cycle completion pulse
//   sum      out  sum of the words copied by the last operation
//   memWR    out  memory write strobe (memory commits on falling clk edge)
//   dataAddr out  memory word address
//   inData   out  memory write data
//   outData  in   combinational memory read data
//
// FSM states
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for start; outputs hold their last values
//   READ     | dataAddr = src+idx; read data captured and summed at edge
//   WRITE    | dataAddr = dst+idx; memWR high; idx advances at edge
//   DONE     | done pulse for one cycle, then back to IDLE
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic              memWR,
  output logic [ADDR_W-1:0] dataAddr,
  output logic [DATA_W-1:0] inData,
  input  logic [DATA_W-1:0] outData
);

  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q,   src_d;
  logic [ADDR_W-1:0] dst_q,   dst_d;
  logic [ADDR_W-1:0] len_q,   len_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] hold_q,  hold_d;
  logic [DATA_W-1:0] sum_q,   sum_d;

  // The memory address is kept in a register loaded one edge early with the
  // address of the state being entered, so it is stable for the whole cycle
  // and simply holds its last value in IDLE/DONE.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    sum_d   = sum_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d = srcAddr;
          dst_d = dstAddr;
          len_d = len;
          idx_d = '0;
          sum_d = '0;
          if (len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
            addr_d  = srcAddr;
          end
        end
      end
      ST_READ: begin
        hold_d  = outData;
        sum_d   = sum_q + outData;
        addr_d  = dst_q + idx_q;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d = idx_q + IDX_ONE;
        if (idx_d == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
          addr_d  = src_q + idx_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      sum_q   <= sum_d;
    end
  end

  // Strobes decode only the state register so memWR cannot glitch around
  // the falling edge where the memory commits.
  assign memWR    = (state_q == ST_WRITE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign dataAddr = addr_q;
  assign inData   = hold_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine
//   Bench for mem_copy_engine with a behavioural data memory peer
//   (combinational read, write on falling edge). A reference model of the
//   memory predicts every write; predicted writes are queued when a copy is
//   launched and popped as the engine strobes memWR.
module tb_mem_copy_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  srcAddr, dstAddr, len;
  logic        busy, done, memWR;
  logic [15:0] sum;
  logic [7:0]  dataAddr;
  logic [15:0] inData, outData;

  logic [15:0] mem [256];
  logic [15:0] mdl [256];
  logic [23:0] exp_q [$];

  logic        clr, poke_en;
  logic [7:0]  poke_a;
  logic [15:0] poke_v;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .srcAddr  (srcAddr),
    .dstAddr  (dstAddr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .memWR    (memWR),
    .dataAddr (dataAddr),
    .inData   (inData),
    .outData  (outData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outData = mem[dataAddr];

  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (poke_en) begin
      mem[poke_a] <= poke_v;
    end else if (memWR) begin
      mem[dataAddr] <= inData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every committed write must match the next predicted one.
  always @(negedge clk) begin
    if (memWR) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {24'd0, dataAddr}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, dataAddr}, {24'd0, e[23:16]});
        chk("wr_data", {16'd0, inData}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [15:0] v);
    poke_a  = a;
    poke_v  = v;
    poke_en = 1'b1;
    mdl[a]  = v;
    @(negedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input logic [15:0] exp_sum, input bit mid_start);
    int busy_cnt, done_cnt, cyc;
    logic [7:0] a;
    for (int i = 0; i < int'(l); i++) begin
      a = s + 8'(i);
      mdl[8'(d + 8'(i))] = mdl[a];
      exp_q.push_back({8'(d + 8'(i)), mdl[a]});
    end
    busy_cnt = 0;
    done_cnt = 0;
    cyc      = 0;
    wr_cnt   = 0;
    @(negedge clk);
    srcAddr = s;
    dstAddr = d;
    len     = l;
    start   = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      start = mid_start && (cyc == 3);
      if (mid_start) begin
        srcAddr = 8'h00;
        dstAddr = 8'h20;
        len     = 8'h01;
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end while (busy && cyc < 1000);
    start = 1'b0;
    chk("copy_timeout", {31'd0, busy}, 32'd0);
    chk("busy_cycles", busy_cnt, (l == 8'd0) ? 32'd1 : 32'(2 * int'(l) + 1));
    chk("done_pulses", done_cnt, 32'd1);
    chk("write_count", wr_cnt, {24'd0, l});
    chk("sum", {16'd0, sum}, {16'd0, exp_sum});
    chk("queue_drained", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    chk("sum_hold", {16'd0, sum}, {16'd0, exp_sum});
  endtask

  initial begin
    int diffs;
    rst_n   = 1'b1;
    start   = 1'b0;
    srcAddr = '0;
    dstAddr = '0;
    len     = '0;
    clr     = 1'b1;
    poke_en = 1'b0;
    poke_a  = '0;
    poke_v  = '0;
    for (int i = 0; i < 256; i++) mdl[i] = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_memwr", {31'd0, memWR}, 32'd0);
    chk("rst_sum",   {16'd0, sum},   32'd0);
    chk("rst_addr",  {24'd0, dataAddr}, 32'd0);
    chk("rst_wdata", {16'd0, inData},   32'd0);
    @(negedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // basic three-word copy
    poke(8'h00, 16'h0002);
    poke(8'h01, 16'h0030);
    poke(8'h02, 16'h000F);
    run_copy(8'h00, 8'h20, 8'd3, 16'h0041, 1'b0);
    chk("basic_m32", {16'd0, mem[32]}, 32'h0002);
    chk("basic_m33", {16'd0, mem[33]}, 32'h0030);
    chk("basic_m34", {16'd0, mem[34]}, 32'h000F);

    // zero-length copy
    run_copy(8'h05, 8'h06, 8'd0, 16'h0000, 1'b0);

    // source address wraps from FF to 00
    poke(8'hFF, 16'hFFE1);
    run_copy(8'hFF, 8'h10, 8'd2, 16'hFFE3, 1'b0);
    chk("wrap_m16", {16'd0, mem[16]}, 32'hFFE1);
    chk("wrap_m17", {16'd0, mem[17]}, 32'h0002);

    // overlapping copy propagates the first word
    poke(8'h00, 16'h1234);
    run_copy(8'h00, 8'h01, 8'd3, 16'h369C, 1'b0);
    chk("ovl_m1", {16'd0, mem[1]}, 32'h1234);
    chk("ovl_m2", {16'd0, mem[2]}, 32'h1234);
    chk("ovl_m3", {16'd0, mem[3]}, 32'h1234);

    // start re-asserted mid-copy with different inputs is ignored
    poke(8'h80, 16'h1111);
    poke(8'h81, 16'h2222);
    poke(8'h82, 16'h3333);
    poke(8'h83, 16'h4444);
    run_copy(8'h80, 8'h90, 8'd4, 16'hAAAA, 1'b1);

    // reset during the second WRITE of a four-word copy
    poke(8'h40, 16'h0A01);
    poke(8'h41, 16'h0A02);
    poke(8'h42, 16'h0A03);
    poke(8'h43, 16'h0A04);
    mdl[8'h50] = 16'h0A01;
    mdl[8'h51] = 16'h0A02;
    exp_q.push_back({8'h50, 16'h0A01});
    exp_q.push_back({8'h51, 16'h0A02});
    @(negedge clk);
    srcAddr = 8'h40;
    dstAddr = 8'h50;
    len     = 8'd4;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_write", {31'd0, memWR}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_memwr", {31'd0, memWR}, 32'd0);
    chk("abort_busy",  {31'd0, busy},  32'd0);
    chk("abort_sum",   {16'd0, sum},   32'd0);
    chk("abort_addr",  {24'd0, dataAddr}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done_after", {31'd0, done}, 32'd0);
    end
    chk("abort_queue", exp_q.size(), 32'd0);
    chk("abort_m50", {16'd0, mem[8'h50]}, 32'h0A01);
    chk("abort_m51", {16'd0, mem[8'h51]}, 32'h0A02);
    chk("abort_m52", {16'd0, mem[8'h52]}, 32'h0000);
    chk("abort_m53", {16'd0, mem[8'h53]}, 32'h0000);
    run_copy(8'h40, 8'h60, 8'd2, 16'h1403, 1'b0);

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mdl[i]) diffs++;
    chk("mem_image", diffs, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
